// File: rtl/timer_pkg.sv
// Shared definitions for the microwave timer sequencer: FSM state encoding
// and BCD digit constants used by the entry buffer and control FSM.
package timer_pkg;

  localparam int               BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Encoding is visible on the debug state port, so values are fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    COOK  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Keypad codes above 9 are function keys and never enter the buffer.
  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/timer_entry_buf.sv
// NDIG-digit BCD entry buffer. A shift pushes the new digit into the least
// significant position and drops the oldest digit; non-BCD digits are refused.
module timer_entry_buf
  import timer_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  shift,
  input  logic                  clr,
  input  logic [BCD_W-1:0]      digit,
  output logic                  digit_ok,
  output logic [NDIG*BCD_W-1:0] data
);

  assign digit_ok = is_bcd(digit);

  // Buffer register: clear wins over shift; shift only accepts BCD digits.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data <= '0;
    end else if (clr) begin
      data <= '0;
    end else if (shift && digit_ok) begin
      data <= {data[(NDIG-1)*BCD_W-1:0], digit};
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Microwave countdown sequencer. Collects keypad digits, loads them into the
// external BCD down-counter chain, gates the 1 Hz tick into it while cooking,
// and drives the magnetron enable and end-of-cook beep. Every output is a
// register fed from the next-state decision, so outputs line up with state.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int BEEP_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  tick,
  input  logic                  key_valid,
  input  logic [BCD_W-1:0]      key_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  door_closed,
  input  logic [NDIG-1:0]       cnt_zero,
  output logic [NDIG*BCD_W-1:0] load_data,
  output logic                  cnt_loadn,
  output logic                  cnt_en,
  output logic                  cnt_clrn,
  output logic                  mag_on,
  output logic                  done,
  output logic [2:0]            state
);

  state_t     state_q, state_d;
  logic [3:0] beep_cnt, beep_d;
  logic       buf_shift, buf_clr, digit_ok, key_hit, zero_all;
  logic       en_d, clrn_d;

  timer_entry_buf #(.NDIG(NDIG)) u_buf (
    .clk      (clk),
    .clrn     (clrn),
    .shift    (buf_shift),
    .clr      (buf_clr),
    .digit    (key_val),
    .digit_ok (digit_ok),
    .data     (load_data)
  );

  assign key_hit  = key_valid & digit_ok;
  assign zero_all = &cnt_zero;
  assign state    = state_q;

  // Next-state, buffer control and next output values.
  // Within each state: clear first, then door/stop, then start, then keys.
  always_comb begin
    state_d   = state_q;
    beep_d    = beep_cnt;
    buf_shift = 1'b0;
    buf_clr   = 1'b0;
    en_d      = 1'b0;
    clrn_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (clear) begin
          buf_clr = 1'b1;
        end else if (key_hit) begin
          buf_shift = 1'b1;
          state_d   = ENTRY;
        end
      end
      ENTRY: begin
        if (clear) begin
          buf_clr = 1'b1;
          state_d = IDLE;
        end else if (start && door_closed && (|load_data)) begin
          state_d = LOAD;
        end else if (key_hit) begin
          buf_shift = 1'b1;
        end
      end
      LOAD: begin
        state_d = COOK;
      end
      COOK: begin
        if (clear) begin
          clrn_d  = 1'b0;
          buf_clr = 1'b1;
          state_d = IDLE;
        end else if (zero_all) begin
          // Expiry beats a same-cycle stop or door opening.
          buf_clr = 1'b1;
          beep_d  = '0;
          state_d = DONE;
        end else if (stop || !door_closed) begin
          state_d = PAUSE;
        end else begin
          // zero_all is false here, so the chain can never wrap to 9s.
          en_d = tick;
        end
      end
      PAUSE: begin
        if (clear) begin
          clrn_d  = 1'b0;
          buf_clr = 1'b1;
          state_d = IDLE;
        end else if (start && door_closed) begin
          state_d = COOK;
        end
      end
      DONE: begin
        // Any key, clear or door opening silences the beep; the key is dropped.
        if (clear || !door_closed || key_hit) begin
          state_d = IDLE;
        end else if (tick) begin
          beep_d = beep_cnt + 4'd1;
          if (beep_cnt == 4'(BEEP_TICKS - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        buf_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
    // Chain only samples the parallel load while enabled.
    if (state_d == LOAD) begin
      en_d = 1'b1;
    end
  end

  // State and output registers; reset holds the chain cleared and the magnetron off.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      beep_cnt  <= '0;
      cnt_loadn <= 1'b1;
      cnt_en    <= 1'b0;
      cnt_clrn  <= 1'b0;
      mag_on    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      beep_cnt  <= beep_d;
      cnt_loadn <= (state_d != LOAD);
      cnt_en    <= en_d;
      cnt_clrn  <= clrn_d;
      mag_on    <= (state_d == COOK);
      done      <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios followed by random stimulus, all
// checked every cycle against a reference model that keeps the entry buffer
// and the counter chain as plain decimal integers.
module tb_timer_ctrl;

  localparam int NDIG = 4;
  localparam int BEEP = 3;
  localparam int MODV = 10000;

  logic              clk = 1'b0;
  logic              clrn = 1'b0;
  logic              tick = 1'b0, key_valid = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic              door_closed = 1'b1;
  logic [3:0]        key_val = 4'd0;
  logic [NDIG-1:0]   cnt_zero;
  logic [4*NDIG-1:0] load_data;
  logic              cnt_loadn, cnt_en, cnt_clrn, mag_on, done;
  logic [2:0]        state;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment: counter chain as a decimal seconds value.
  int chain = 0;

  // Reference model: mode number as listed in the state table, buffer as decimal.
  int   m_state = 0, m_buf = 0, m_beep = 0;
  logic e_loadn = 1'b1, e_en = 1'b0, e_clrn = 1'b0, e_mag = 1'b0, e_done = 1'b0;

  timer_ctrl #(.NDIG(NDIG), .BEEP_TICKS(BEEP)) dut (
    .clk(clk), .clrn(clrn), .tick(tick), .key_valid(key_valid), .key_val(key_val),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
    .cnt_zero(cnt_zero), .load_data(load_data), .cnt_loadn(cnt_loadn), .cnt_en(cnt_en),
    .cnt_clrn(cnt_clrn), .mag_on(mag_on), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [4*NDIG-1:0] to_bcd(input int val);
    logic [4*NDIG-1:0] r;
    int v;
    v = val;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [4*NDIG-1:0] d);
    int v;
    v = 0;
    for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + int'(d[4*i +: 4]);
    return v;
  endfunction

  // Counter chain reacting to the DUT's control outputs.
  always @(posedge clk) begin
    if (!cnt_clrn)                chain <= 0;
    else if (cnt_en && !cnt_loadn) chain <= from_bcd(load_data);
    else if (cnt_en)              chain <= (chain == 0) ? MODV - 1 : chain - 1;
  end

  always_comb begin
    int v;
    v = chain;
    for (int i = 0; i < NDIG; i++) begin
      cnt_zero[i] = ((v % 10) == 0);
      v = v / 10;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_buf = 0; m_beep = 0;
    e_loadn = 1'b1; e_en = 1'b0; e_clrn = 1'b0; e_mag = 1'b0; e_done = 1'b0;
  endtask

  // One clock of the behavioural rules, using the inputs present this cycle.
  task automatic model_step();
    bit kh, zall;
    int nx;
    kh   = key_valid && (key_val <= 4'd9);
    zall = (chain == 0);
    nx   = m_state;
    e_en = 1'b0;
    e_clrn = 1'b1;
    case (m_state)
      0: if (clear) m_buf = 0;
         else if (kh) begin m_buf = (m_buf * 10 + int'(key_val)) % MODV; nx = 1; end
      1: if (clear) begin m_buf = 0; nx = 0; end
         else if (start && door_closed && m_buf != 0) nx = 2;
         else if (kh) m_buf = (m_buf * 10 + int'(key_val)) % MODV;
      2: nx = 3;
      3: if (clear) begin e_clrn = 1'b0; m_buf = 0; nx = 0; end
         else if (zall) begin m_buf = 0; m_beep = 0; nx = 5; end
         else if (stop || !door_closed) nx = 4;
         else e_en = tick;
      4: if (clear) begin e_clrn = 1'b0; m_buf = 0; nx = 0; end
         else if (start && door_closed) nx = 3;
      5: if (clear || !door_closed || kh) nx = 0;
         else if (tick) begin m_beep++; if (m_beep >= BEEP) nx = 0; end
      default: nx = 0;
    endcase
    m_state = nx;
    e_loadn = (nx != 2);
    if (nx == 2) e_en = 1'b1;
    e_mag  = (nx == 3);
    e_done = (nx == 5);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("state", state, m_state);
    chk("load_data", load_data, to_bcd(m_buf));
    chk("cnt_loadn", cnt_loadn, e_loadn);
    chk("cnt_en", cnt_en, e_en);
    chk("cnt_clrn", cnt_clrn, e_clrn);
    chk("mag_on", mag_on, e_mag);
    chk("done", done, e_done);
    tick = 1'b0; key_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1; key_val = d; cyc();
  endtask

  // Ticks are kept at least three cycles apart, as with a real 1 Hz strobe.
  task automatic do_tick();
    tick = 1'b1; cyc(); cyc(); cyc();
  endtask

  task automatic start_cook();
    start = 1'b1; cyc(); cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int saved, since;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_loadn", cnt_loadn, 1);
    chk("rst_en", cnt_en, 0);
    chk("rst_clrn", cnt_clrn, 0);
    chk("rst_mag", mag_on, 0);
    chk("rst_done", done, 0);
    clrn = 1'b1;
    model_reset();
    cyc();
    chk("clrn_release", cnt_clrn, 1);

    // 1: keys 1,3,0 then start
    key(4'd1); key(4'd3); key(4'd0);
    chk("t1_load_data", load_data, 16'h0130);
    start = 1'b1; cyc();
    chk("t1_loadn_low", cnt_loadn, 0);
    chk("t1_state_load", state, 2);
    cyc();
    chk("t1_loadn_high", cnt_loadn, 1);
    chk("t1_mag_on", mag_on, 1);
    chk("t1_chain", chain, 130);
    clear = 1'b1; cyc();
    chk("t1_clear_clrn", cnt_clrn, 0);
    cyc();

    // 2: cook from 0001 to expiry, then beep for three ticks
    key(4'd1); start_cook();
    chk("t2_chain", chain, 1);
    do_tick();
    chk("t2_done", done, 1);
    chk("t2_mag_off", mag_on, 0);
    do_tick(); do_tick();
    chk("t2_still_done", state, 5);
    do_tick();
    chk("t2_idle", state, 0);

    // 3: door opens mid-cook, count frozen, resume without reload
    key(4'd5); start_cook(); do_tick();
    door_closed = 1'b0; cyc();
    chk("t3_pause", state, 4);
    chk("t3_mag_off", mag_on, 0);
    saved = chain;
    repeat (5) do_tick();
    chk("t3_frozen", chain, saved);
    door_closed = 1'b1; start = 1'b1; cyc();
    chk("t3_resume", state, 3);
    chk("t3_no_reload", cnt_loadn, 1);
    clear = 1'b1; cyc(); cyc();

    // 4: overflowing entry, non-BCD key, start with empty buffer
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("t4_shift", load_data, 16'h2345);
    key(4'd12);
    chk("t4_nonbcd", load_data, 16'h2345);
    clear = 1'b1; cyc();
    key(4'd0);
    start = 1'b1; cyc();
    chk("t4_start_zero", state, 1);
    clear = 1'b1; cyc();

    // 5: expiry beats door opening; clear while cooking
    key(4'd1); start_cook();
    tick = 1'b1; cyc(); cyc();
    door_closed = 1'b0; cyc();
    chk("t5_done_not_pause", state, 5);
    cyc();
    door_closed = 1'b1;
    key(4'd2); start_cook();
    clear = 1'b1; cyc();
    chk("t5_clrn_pulse", cnt_clrn, 0);
    chk("t5_idle", state, 0);
    cyc();
    chk("t5_clrn_back", cnt_clrn, 1);

    // 6: asynchronous reset mid-cook
    key(4'd7); start_cook(); cyc();
    #2;
    clrn = 1'b0;
    #1;
    chk("t6_mag", mag_on, 0);
    chk("t6_clrn", cnt_clrn, 0);
    chk("t6_state", state, 0);
    chk("t6_en", cnt_en, 0);
    chk("t6_load_data", load_data, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    clrn = 1'b1;
    cyc();
    chk("t6_chain_cleared", chain, 0);
    chk("t6_idle", state, 0);

    // Random stimulus
    since = 3;
    for (int n = 0; n < 3000; n++) begin
      if (since >= 3 && $urandom_range(0, 3) == 0) begin tick = 1'b1; since = 0; end
      else since++;
      if ($urandom_range(0, 5) == 0) begin
        key_valid = 1'b1;
        key_val = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
      end
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) door_closed = ~door_closed;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
